frame_buffer_ctrl: RTL and testbench
====================================

FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 Parameter H_PIX, default 160, pixels per line.
REQ-002 Parameter V_PIX, default 120, lines per frame; address width = $clog2(H_PIX*V_PIX) = 15.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  capture enable.
REQ-006 cam_vsync  input  1  camera frame-start level; its rising edge marks frame start.
REQ-007 pix_valid  input  1  pix_data valid this cycle.
REQ-008 pix_data  input  16  RGB565 pixel.
REQ-009 rd_frame_end  input  1  one-cycle pulse from the display side at the end of its read frame (same clock domain).
REQ-010 err_clr  input  1  clears sticky error flags.
REQ-011 we  output  1  frame buffer write enable.
REQ-012 wAddr  output  15  frame buffer write address.
REQ-013 wData  output  16  frame buffer write data.
REQ-014 buffer_sel  output  1  buffer currently being written; the display reads the other buffer.
REQ-015 frame_cnt  output  8  completed-and-swapped frame count.
REQ-016 ovf_err  output  1  sticky flag: pixels arrived after the frame was full.
REQ-017 short_err  output  1  sticky flag: new frame started before the current frame was full.
REQ-018 busy  output  1  high in CAPTURE or WAIT_SWAP.

Function
REQ-019 FSM states SHALL be IDLE, WAIT_VSYNC, CAPTURE and WAIT_SWAP.
REQ-020 IDLE->WAIT_VSYNC when en=1; en=0 in WAIT_VSYNC SHALL return the FSM to IDLE; en is ignored in CAPTURE and WAIT_SWAP, so a frame in progress completes.
REQ-021 WAIT_VSYNC->CAPTURE on a cam_vsync rising edge (registered edge detect); x and y counters SHALL be zeroed.
REQ-022 In CAPTURE, each pix_valid SHALL produce, exactly 1 cycle later: we=1, wData=pix_data, wAddr=y*H_PIX+x.
REQ-023 wAddr SHALL be maintained incrementally, with no multiplier.
REQ-024 x SHALL wrap from H_PIX-1 to 0 and increment y.
REQ-025 The write of pixel index H_PIX*V_PIX-1 (x=H_PIX-1, y=V_PIX-1) SHALL move the FSM to WAIT_SWAP.
REQ-026 we SHALL be 0 in every cycle not covered by REQ-022.
REQ-027 In WAIT_SWAP, rd_frame_end SHALL, on the same edge:
- toggle buffer_sel;
- increment frame_cnt (wrapping 255->0);
- move the FSM to WAIT_VSYNC.
REQ-028 pix_valid in WAIT_SWAP SHALL NOT write and SHALL set ovf_err.
REQ-029 A cam_vsync rising edge in WAIT_SWAP SHALL be ignored; that camera frame is dropped.
REQ-030 A cam_vsync rising edge in CAPTURE before the frame is full SHALL:
- set short_err;
- zero x and y;
- stay in CAPTURE;
- leave buffer_sel unchanged.
REQ-031 If pix_valid and a cam_vsync rising edge occur in the same cycle in CAPTURE, the vsync edge SHALL take priority and that pixel SHALL be written at address 0.
REQ-032 rd_frame_end outside WAIT_SWAP SHALL be ignored.
REQ-033 buffer_sel SHALL never change in IDLE, WAIT_VSYNC or CAPTURE.
REQ-034 err_clr SHALL clear ovf_err and short_err; a set condition in the same cycle as err_clr SHALL win.

Reset
REQ-035 On reset, outputs SHALL be: state=IDLE, we=0, wAddr=0, wData=0, buffer_sel=0, frame_cnt=0, ovf_err=0, short_err=0, busy=0.
REQ-036 Reset SHALL also clear x, y and the vsync edge register.
REQ-037 Reset asserted mid-CAPTURE SHALL abort the frame with no further writes; capture resumes only after en=1 and a fresh cam_vsync rising edge.

Structure
REQ-038 Package fb_pkg SHALL hold:
- H_PIX and V_PIX defaults;
- FB_DEPTH (H_PIX*V_PIX) and FB_AW;
- the FSM state enum fb_ctrl_state_t.
REQ-039 One sub-module, fb_addr_gen, SHALL hold the x/y/address counters with clear and step inputs and a last-pixel output; the FSM and output registers SHALL stay in frame_buffer_ctrl.

Verification
REQ-040 Full frame: en=1, vsync edge, 19200 pix_valid with pix_data=index -> 19200 writes, wAddr 0..19199 in order, each 1 cycle after its pixel; FSM in WAIT_SWAP; buffer_sel=0.
REQ-041 Swap: then rd_frame_end pulse -> buffer_sel=1 and frame_cnt=1 on the next edge; a second full frame plus rd_frame_end -> buffer_sel=0, frame_cnt=2.
REQ-042 Short frame: vsync edge after 500 pixels -> short_err=1; next pixel written at wAddr=0; no swap.
REQ-043 Overflow: 3 pix_valid in WAIT_SWAP -> ovf_err=1, we stays 0; err_clr -> ovf_err=0.
REQ-044 Reset mid-frame: reset asserted at pixel 1000 -> all outputs at reset values immediately; no we until en=1 and a new vsync edge.
REQ-045 Ignored events: rd_frame_end during CAPTURE and vsync during WAIT_SWAP -> buffer_sel and frame_cnt unchanged.

Source files
------------

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared definitions for the camera frame-buffer write controller.
//            Holds default frame geometry, derived buffer depth / address
//            width, the controller state encoding and a small state helper.
// Revision : 1.0  initial release
// ============================================================================
package fb_pkg;

    // Default frame geometry (QQVGA)
    localparam int H_PIX_DEFAULT = 160;
    localparam int V_PIX_DEFAULT = 120;

    // One buffer holds one full frame of RGB565 pixels
    localparam int FB_DEPTH = H_PIX_DEFAULT * V_PIX_DEFAULT;
    localparam int FB_AW    = $clog2(FB_DEPTH);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VSYNC = 2'd1,
        CAPTURE    = 2'd2,
        WAIT_SWAP  = 2'd3
    } fb_ctrl_state_t;

    // A frame is "in flight" from the first accepted vsync edge until the
    // display side hands the buffer over.
    function automatic logic fb_state_busy(input fb_ctrl_state_t s);
        return (s == CAPTURE) || (s == WAIT_SWAP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fb_addr_gen
// Purpose  : Raster x/y position and linear write address for one frame.
//            The linear address is carried alongside x/y and incremented,
//            so no y*H_PIX multiply is ever needed.
// Ports    : clk, reset      - clock, async active-high reset
//            clear           - restart the frame at (0,0)
//            step            - consume one pixel at the current position
//            addr  [AW-1:0]  - address of the pixel consumed by step now
//            last            - current position is the final pixel of frame
// Notes    : clear and step may be asserted together; the pixel is then
//            taken at address 0 and the counters land on position 1.
// Revision : 1.0  initial release
// ============================================================================
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter  int H_PIX = H_PIX_DEFAULT,
    parameter  int V_PIX = V_PIX_DEFAULT,
    localparam int AW    = $clog2(H_PIX * V_PIX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_addr;

    // Position as seen this cycle: a clear restarts the frame immediately so
    // a pixel arriving in the same cycle is placed at the origin.
    logic [XW-1:0] w_x_cur;
    logic [YW-1:0] w_y_cur;
    logic [AW-1:0] w_addr_cur;
    logic          w_x_end;
    logic          w_y_end;

    assign w_x_cur    = clear ? '0 : r_x;
    assign w_y_cur    = clear ? '0 : r_y;
    assign w_addr_cur = clear ? '0 : r_addr;

    assign w_x_end = (w_x_cur == XW'(H_PIX - 1));
    assign w_y_end = (w_y_cur == YW'(V_PIX - 1));

    assign addr = w_addr_cur;
    assign last = w_x_end && w_y_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (step) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : (w_y_cur + YW'(1));
            end else begin
                r_x <= w_x_cur + XW'(1);
            end
            r_addr <= last ? '0 : (w_addr_cur + AW'(1));
        end else if (clear) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_ctrl
// Purpose  : Double-buffered camera frame capture controller. Writes one
//            camera frame into the buffer selected by buffer_sel, then waits
//            for the display to finish its read frame before swapping.
// Ports    : clk, reset          - clock, async active-high reset
//            en                  - capture enable (sampled outside a frame)
//            cam_vsync           - camera frame start (rising edge)
//            pix_valid, pix_data - incoming RGB565 pixel stream
//            rd_frame_end        - display finished reading its buffer
//            err_clr             - clear sticky error flags
//            we, wAddr, wData    - frame buffer write port (registered)
//            buffer_sel          - buffer being written
//            frame_cnt           - completed-and-swapped frames (wraps)
//            ovf_err, short_err  - sticky overflow / short-frame flags
//            busy                - frame in flight (CAPTURE or WAIT_SWAP)
// Revision : 1.0  initial release
// ============================================================================
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter  int H_PIX = H_PIX_DEFAULT,
    parameter  int V_PIX = V_PIX_DEFAULT,
    localparam int AW    = $clog2(H_PIX * V_PIX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          cam_vsync,
    input  logic          pix_valid,
    input  logic [15:0]   pix_data,
    input  logic          rd_frame_end,
    input  logic          err_clr,
    output logic          we,
    output logic [AW-1:0] wAddr,
    output logic [15:0]   wData,
    output logic          buffer_sel,
    output logic [7:0]    frame_cnt,
    output logic          ovf_err,
    output logic          short_err,
    output logic          busy
);

    fb_ctrl_state_t r_state;
    fb_ctrl_state_t w_state_nxt;

    logic          r_vsync_d;
    logic          w_vsync_rise;

    logic          w_gen_clear;
    logic          w_gen_step;
    logic [AW-1:0] w_gen_addr;
    logic          w_gen_last;

    logic          w_we_nxt;
    logic          w_swap;
    logic          w_ovf_set;
    logic          w_short_set;

    // Rising edge of the camera frame strobe against its registered copy
    assign w_vsync_rise = cam_vsync && !r_vsync_d;

    fb_addr_gen #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX)
    ) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .clear (w_gen_clear),
        .step  (w_gen_step),
        .addr  (w_gen_addr),
        .last  (w_gen_last)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = WAIT_VSYNC;
                end
            end
            WAIT_VSYNC: begin
                // Dropping en wins over a simultaneous frame start
                if (!en) begin
                    w_state_nxt = IDLE;
                end else if (w_vsync_rise) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                // A restart via vsync stays here; only the final write leaves
                if (w_gen_step && w_gen_last) begin
                    w_state_nxt = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (rd_frame_end) begin
                    w_state_nxt = WAIT_VSYNC;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_gen_clear = 1'b0;
        w_gen_step  = 1'b0;
        w_we_nxt    = 1'b0;
        w_swap      = 1'b0;
        w_ovf_set   = 1'b0;
        w_short_set = 1'b0;
        case (r_state)
            WAIT_VSYNC: begin
                w_gen_clear = w_vsync_rise;
            end
            CAPTURE: begin
                // Every frame restart inside CAPTURE is premature: a full
                // frame has already moved us to WAIT_SWAP.
                w_gen_clear = w_vsync_rise;
                w_short_set = w_vsync_rise;
                w_gen_step  = pix_valid;
                w_we_nxt    = pix_valid;
            end
            WAIT_SWAP: begin
                w_ovf_set = pix_valid;
                w_swap    = rd_frame_end;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_d  <= 1'b0;
            we         <= 1'b0;
            wAddr      <= '0;
            wData      <= '0;
            buffer_sel <= 1'b0;
            frame_cnt  <= 8'd0;
            ovf_err    <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            r_vsync_d <= cam_vsync;
            we        <= w_we_nxt;
            // Address/data hold their last value between writes
            if (w_we_nxt) begin
                wAddr <= w_gen_addr;
                wData <= pix_data;
            end
            if (w_swap) begin
                buffer_sel <= !buffer_sel;
                frame_cnt  <= frame_cnt + 8'd1;
            end
            // Sticky flags: a new error event outranks a clear request
            ovf_err   <= w_ovf_set   || (ovf_err   && !err_clr);
            short_err <= w_short_set || (short_err && !err_clr);
        end
    end

    assign busy = fb_state_busy(r_state);

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buffer_ctrl
// Purpose  : Directed self-checking bench for frame_buffer_ctrl (160x120).
// Revision : 1.0  initial release
// ============================================================================
module tb_frame_buffer_ctrl;

    localparam int H     = 160;
    localparam int V     = 120;
    localparam int DEPTH = H * V;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        cam_vsync;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        rd_frame_end;
    logic        err_clr;
    logic        we;
    logic [14:0] wAddr;
    logic [15:0] wData;
    logic        buffer_sel;
    logic [7:0]  frame_cnt;
    logic        ovf_err;
    logic        short_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_buffer_ctrl #(
        .H_PIX (H),
        .V_PIX (V)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .cam_vsync    (cam_vsync),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .rd_frame_end (rd_frame_end),
        .err_clr      (err_clr),
        .we           (we),
        .wAddr        (wAddr),
        .wData        (wData),
        .buffer_sel   (buffer_sel),
        .frame_cnt    (frame_cnt),
        .ovf_err      (ovf_err),
        .short_err    (short_err),
        .busy         (busy)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_edge();
        cam_vsync = 1'b1;
        tick();
        cam_vsync = 1'b0;
        tick();
    endtask

    // Streams pixels start..start+n-1 with pix_data = index; expects each on
    // the write port one cycle later at wAddr = index. Idle gaps are inserted
    // periodically and must show we=0. rdfe_at pulses rd_frame_end at that
    // pixel (-1 for none). Returns the number of bad cycles.
    task automatic send_pixels(input int start, input int n, input int rdfe_at,
                               output int bad);
        bad = 0;
        for (int i = start; i < start + n; i++) begin
            if ((i % 97) == 50) begin
                pix_valid = 1'b0;
                tick();
                if (we !== 1'b0) begin
                    if (bad == 0) $display("  first bad cycle: gap before idx %0d we=%0b", i, we);
                    bad++;
                end
            end
            pix_valid    = 1'b1;
            pix_data     = i[15:0];
            rd_frame_end = (i == rdfe_at);
            tick();
            rd_frame_end = 1'b0;
            if (we !== 1'b1 || wAddr !== i[14:0] || wData !== i[15:0]) begin
                if (bad == 0) $display("  first bad cycle: idx %0d we=%0b wAddr=%0d wData=%0d",
                                       i, we, wAddr, wData);
                bad++;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; cam_vsync = 1'b0; pix_valid = 1'b0;
        pix_data = 16'h0; rd_frame_end = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", we); end
        checks++; if (wAddr !== 15'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", wAddr); end
        checks++; if (wData !== 16'd0) begin errors++; $display("FAIL reset_wdata got %0h want 0", wData); end
        checks++; if ({buffer_sel, frame_cnt} !== 9'd0) begin errors++; $display("FAIL reset_sel_cnt got %0b/%0d want 0/0", buffer_sel, frame_cnt); end
        checks++; if ({ovf_err, short_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %0b%0b want 00", ovf_err, short_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        int bad;
        en = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_vsync_busy got %0b want 0", busy); end
        vsync_edge();
        checks++; if (busy !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL capture_entry got busy=%0b we=%0b want 1/0", busy, we); end
        // rd_frame_end mid-capture must be ignored
        send_pixels(0, DEPTH, 1234, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_frame_writes got %0d bad cycles want 0", bad); end
        checks++; if (buffer_sel !== 1'b0 || frame_cnt !== 8'd0) begin errors++; $display("FAIL full_frame_sel_cnt got %0b/%0d want 0/0", buffer_sel, frame_cnt); end
        tick();
        checks++; if (we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wait_swap_entry got we=%0b busy=%0b want 0/1", we, busy); end
    endtask

    task automatic test_overflow();
        logic we_seen;
        we_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pix_valid = 1'b1;
            pix_data  = 16'hDEAD;
            tick();
            we_seen = we_seen | we;
        end
        pix_valid = 1'b0;
        checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL ovf_no_write got we=%0b want 0", we_seen); end
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", ovf_err); end
        // Same-cycle set and clear: set wins
        pix_valid = 1'b1; err_clr = 1'b1;
        tick();
        pix_valid = 1'b0;
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clr got %0b want 1", ovf_err); end
        tick();
        err_clr = 1'b0;
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b want 0", ovf_err); end
    endtask

    task automatic test_ignored_vsync();
        vsync_edge();
        checks++; if (buffer_sel !== 1'b0 || frame_cnt !== 8'd0 || busy !== 1'b1) begin errors++; $display("FAIL swap_vsync_ignored got sel=%0b cnt=%0d busy=%0b want 0/0/1", buffer_sel, frame_cnt, busy); end
        pix_valid = 1'b1; pix_data = 16'hBEEF;
        tick();
        pix_valid = 1'b0;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL swap_vsync_no_capture got we=%0b want 0", we); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_swap();
        int bad;
        rd_frame_end = 1'b1;
        tick();
        rd_frame_end = 1'b0;
        checks++; if (buffer_sel !== 1'b1 || frame_cnt !== 8'd1) begin errors++; $display("FAIL swap1 got sel=%0b cnt=%0d want 1/1", buffer_sel, frame_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swap1_busy got %0b want 0", busy); end
        vsync_edge();
        // en is don't-care once a frame is under way
        en = 1'b0;
        send_pixels(0, DEPTH, -1, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL frame2_writes got %0d bad cycles want 0", bad); end
        checks++; if (buffer_sel !== 1'b1) begin errors++; $display("FAIL frame2_sel_hold got %0b want 1", buffer_sel); end
        rd_frame_end = 1'b1;
        tick();
        rd_frame_end = 1'b0;
        en = 1'b1;
        checks++; if (buffer_sel !== 1'b0 || frame_cnt !== 8'd2) begin errors++; $display("FAIL swap2 got sel=%0b cnt=%0d want 0/2", buffer_sel, frame_cnt); end
    endtask

    task automatic test_short_frame();
        int bad;
        vsync_edge();
        send_pixels(0, 500, -1, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL short_pre_writes got %0d bad want 0", bad); end
        cam_vsync = 1'b1;
        tick();
        cam_vsync = 1'b0;
        checks++; if (short_err !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL short_err_set got err=%0b we=%0b want 1/0", short_err, we); end
        pix_valid = 1'b1; pix_data = 16'h1111;
        tick();
        pix_valid = 1'b0;
        checks++; if (we !== 1'b1 || wAddr !== 15'd0 || wData !== 16'h1111) begin errors++; $display("FAIL short_restart got we=%0b addr=%0d data=%0h want 1/0/1111", we, wAddr, wData); end
        checks++; if (buffer_sel !== 1'b0 || frame_cnt !== 8'd2 || busy !== 1'b1) begin errors++; $display("FAIL short_no_swap got sel=%0b cnt=%0d busy=%0b want 0/2/1", buffer_sel, frame_cnt, busy); end
        send_pixels(1, 20, -1, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL short_post_writes got %0d bad want 0", bad); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL short_clr got %0b want 0", short_err); end
        // vsync edge and pixel together: restart first, pixel lands at 0
        cam_vsync = 1'b1; pix_valid = 1'b1; pix_data = 16'h2222;
        tick();
        cam_vsync = 1'b0; pix_valid = 1'b0;
        checks++; if (we !== 1'b1 || wAddr !== 15'd0 || wData !== 16'h2222) begin errors++; $display("FAIL vsync_pix_same got we=%0b addr=%0d data=%0h want 1/0/2222", we, wAddr, wData); end
        checks++; if (short_err !== 1'b1) begin errors++; $display("FAIL vsync_pix_short got %0b want 1", short_err); end
    endtask

    task automatic test_reset_mid_frame();
        int   bad;
        logic we_seen;
        send_pixels(1, 999, -1, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_pre_writes got %0d bad want 0", bad); end
        pix_valid = 1'b1; pix_data = 16'd1000;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (we !== 1'b0 || wAddr !== 15'd0 || wData !== 16'd0) begin errors++; $display("FAIL mid_reset_port got we=%0b addr=%0d data=%0h want 0/0/0", we, wAddr, wData); end
        checks++; if (frame_cnt !== 8'd0 || buffer_sel !== 1'b0 || short_err !== 1'b0 || ovf_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_status got cnt=%0d sel=%0b short=%0b ovf=%0b busy=%0b want 0/0/0/0/0", frame_cnt, buffer_sel, short_err, ovf_err, busy); end
        tick();
        reset = 1'b0;
        en = 1'b0;
        we_seen = 1'b0;
        // Pixels and a vsync edge while disabled: nothing may be written
        for (int k = 0; k < 4; k++) begin tick(); we_seen = we_seen | we; end
        cam_vsync = 1'b1; tick(); we_seen = we_seen | we;
        cam_vsync = 1'b0; tick(); we_seen = we_seen | we;
        // Enabled but no fresh vsync edge yet
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin tick(); we_seen = we_seen | we; end
        // Dropping en while waiting returns to IDLE, so this edge is lost
        en = 1'b0; tick(); we_seen = we_seen | we;
        cam_vsync = 1'b1; tick(); we_seen = we_seen | we;
        cam_vsync = 1'b0; tick(); we_seen = we_seen | we;
        for (int k = 0; k < 3; k++) begin tick(); we_seen = we_seen | we; end
        pix_valid = 1'b0;
        checks++; if (we_seen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_no_write got we_seen=%0b busy=%0b want 0/0", we_seen, busy); end
        en = 1'b1;
        tick();
        vsync_edge();
        pix_valid = 1'b1; pix_data = 16'h3333;
        tick();
        pix_valid = 1'b0;
        checks++; if (we !== 1'b1 || wAddr !== 15'd0 || wData !== 16'h3333 || busy !== 1'b1) begin errors++; $display("FAIL post_reset_resume got we=%0b addr=%0d data=%0h busy=%0b want 1/0/3333/1", we, wAddr, wData, busy); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_overflow();
        test_ignored_vsync();
        test_swap();
        test_short_frame();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
